// File: rtl/demux_pkg.sv
// Shared types and defaults for the 1-to-2 stream demultiplexer.
// The buffer state encoding is fixed so any module can decode it directly.
package demux_pkg;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/demux_2_stream_if.sv
// Stream bundle for demux_2_stream: one producer stream in, two consumer streams out.
// master = producer/consumer side, slave = the demultiplexer.
interface demux_2_stream_if #(
   parameter int WIDTH = demux_pkg::DEF_WIDTH,
   parameter int CNT_W = demux_pkg::DEF_CNT_W
) ();

   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;

   logic [WIDTH-1:0] a_data;
   logic             a_valid;
   logic             a_ready;
   logic [CNT_W-1:0] a_cnt;

   logic [WIDTH-1:0] b_data;
   logic             b_valid;
   logic             b_ready;
   logic [CNT_W-1:0] b_cnt;

   modport master (
      output in_data, in_sel, in_valid, a_ready, b_ready,
      input  in_ready, a_data, a_valid, a_cnt, b_data, b_valid, b_cnt
   );

   modport slave (
      input  in_data, in_sel, in_valid, a_ready, b_ready,
      output in_ready, a_data, a_valid, a_cnt, b_data, b_valid, b_cnt
   );

endinterface

// File: rtl/skid_buf_2.sv
// Two-entry output buffer with a delivered-word counter.
// Head is always the oldest word; a push with a simultaneous pop in ONE replaces it.
module skid_buf_2
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_valid,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_cnt
);

   buf_state_e       state_q, state_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pop;

   assign out_valid = (state_q != BUF_EMPTY);
   assign full      = (state_q == BUF_FULL);
   assign out_data  = head_q;
   assign out_cnt   = cnt_q;
   assign pop       = out_valid && out_ready;

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path can infer a latch.
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      cnt_d   = cnt_q;
      if (pop) cnt_d = cnt_q + CNT_W'(1);

      case (state_q)
         BUF_EMPTY: begin
            if (push_valid) begin
               state_d = BUF_ONE;
               head_d  = push_data;
            end
         end
         BUF_ONE: begin
            if (push_valid && !pop) begin
               state_d = BUF_FULL;
               tail_d  = push_data;
            end else if (push_valid && pop) begin
               head_d  = push_data;
            end else if (pop) begin
               state_d = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            // Upstream sees full and never pushes here.
            if (pop) begin
               state_d = BUF_ONE;
               head_d  = tail_q;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments only; the payload
   // registers are reset as well because the output data must read 0 after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= BUF_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/demux_2_stream.sv
// Registered 1-to-2 stream demultiplexer: in_sel steers each word to buffer A or B.
// in_ready depends only on in_sel and the registered full flags, never on sink ready.
module demux_2_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   demux_2_stream_if.slave   bus
);

   logic a_full;
   logic b_full;
   logic in_fire;

   assign bus.in_ready = bus.in_sel ? !b_full : !a_full;
   assign in_fire      = bus.in_valid && bus.in_ready;

   skid_buf_2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_buf_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (in_fire && !bus.in_sel),
      .push_data  (bus.in_data),
      .full       (a_full),
      .out_valid  (bus.a_valid),
      .out_ready  (bus.a_ready),
      .out_data   (bus.a_data),
      .out_cnt    (bus.a_cnt)
   );

   skid_buf_2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_buf_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (in_fire && bus.in_sel),
      .push_data  (bus.in_data),
      .full       (b_full),
      .out_valid  (bus.b_valid),
      .out_ready  (bus.b_ready),
      .out_data   (bus.b_data),
      .out_cnt    (bus.b_cnt)
   );

endmodule

// File: tb/tb_demux_2_stream.sv
// Self-checking bench for demux_2_stream: directed scenarios plus random traffic,
// checked every cycle against per-output word queues and modular delivery counts.
module tb_demux_2_stream;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   demux_2_stream_if #(.WIDTH(8), .CNT_W(8)) bus ();
   demux_2_stream_if #(.WIDTH(8), .CNT_W(4)) bus4 ();

   demux_2_stream #(.WIDTH(8), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Narrow-counter copy sees identical traffic; only its counters are compared.
   demux_2_stream #(.WIDTH(8), .CNT_W(4)) dut_w4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   assign bus4.in_data  = bus.in_data;
   assign bus4.in_sel   = bus.in_sel;
   assign bus4.in_valid = bus.in_valid;
   assign bus4.a_ready  = bus.a_ready;
   assign bus4.b_ready  = bus.b_ready;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words accepted but not yet delivered, per output.
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   int         cnt_a = 0;
   int         cnt_b = 0;
   bit         a_zero = 1'b0;
   bit         b_zero = 1'b0;
   bit         live = 1'b0;

   always @(negedge clk) begin
      bit exp_rdy;
      if (!rst_n) begin
         qa.delete();
         qb.delete();
         cnt_a  = 0;
         cnt_b  = 0;
         a_zero = 1'b1;
         b_zero = 1'b1;
         live   = 1'b1;
      end else if (live) begin
         exp_rdy = bus.in_sel ? (qb.size() < 2) : (qa.size() < 2);
         check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
         check("a_valid", 32'(bus.a_valid), 32'(qa.size() != 0));
         check("b_valid", 32'(bus.b_valid), 32'(qb.size() != 0));
         if (qa.size() != 0)  check("a_data", 32'(bus.a_data), 32'(qa[0]));
         else if (a_zero)     check("a_data_rst", 32'(bus.a_data), 32'h0);
         if (qb.size() != 0)  check("b_data", 32'(bus.b_data), 32'(qb[0]));
         else if (b_zero)     check("b_data_rst", 32'(bus.b_data), 32'h0);
         check("a_cnt", 32'(bus.a_cnt), 32'(cnt_a));
         check("b_cnt", 32'(bus.b_cnt), 32'(cnt_b));
         check("a_cnt_w4", 32'(bus4.a_cnt), 32'(cnt_a % 16));
         check("b_cnt_w4", 32'(bus4.b_cnt), 32'(cnt_b % 16));

         // Apply what the next rising edge will do.
         if (qa.size() != 0 && bus.a_ready) begin
            void'(qa.pop_front());
            cnt_a = (cnt_a + 1) % 256;
         end
         if (qb.size() != 0 && bus.b_ready) begin
            void'(qb.pop_front());
            cnt_b = (cnt_b + 1) % 256;
         end
         if (bus.in_valid && exp_rdy) begin
            if (bus.in_sel) begin
               qb.push_back(bus.in_data);
               b_zero = 1'b0;
            end else begin
               qa.push_back(bus.in_data);
               a_zero = 1'b0;
            end
         end
      end
   end

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one word and hold it until accepted, with a cycle budget.
   task automatic send(input logic sel, input logic [7:0] data);
      bit acc;
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_sel   = sel;
      bus.in_data  = data;
      forever begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         n++;
         if (n > 50) begin
            check("send_timeout", 32'(n), 32'(0));
            break;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic do_reset(input int cycles, input logic hold_valid);
      rst_n        = 1'b0;
      bus.in_valid = hold_valid;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_sel   = 1'b0;
      bus.in_data  = 8'h00;
      bus.a_ready  = 1'b1;
      bus.b_ready  = 1'b1;
      #1;

      // Reset with traffic presented: nothing may be captured.
      bus.in_data = 8'h5A;
      do_reset(2, 1'b1);
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'h1);
      check("rst_a_valid", 32'(bus.a_valid), 32'h0);
      check("rst_b_valid", 32'(bus.b_valid), 32'h0);
      @(posedge clk);
      #1;

      // Steering.
      send(1'b0, 8'h11);
      send(1'b1, 8'h22);
      idle(2);
      @(negedge clk);
      check("steer_a_cnt", 32'(bus.a_cnt), 32'd1);
      check("steer_b_cnt", 32'(bus.b_cnt), 32'd1);
      @(posedge clk);
      #1;

      // Backpressure on A must not block B.
      bus.a_ready = 1'b0;
      send(1'b0, 8'hA0);
      send(1'b0, 8'hA1);
      bus.in_valid = 1'b1;
      bus.in_sel   = 1'b0;
      bus.in_data  = 8'hA2;
      @(negedge clk);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'h0);
      @(posedge clk);
      #1;
      send(1'b1, 8'hB0);
      bus.a_ready = 1'b1;
      send(1'b0, 8'hA2);
      idle(4);
      @(negedge clk);
      check("bp_a_cnt", 32'(bus.a_cnt), 32'd4);
      check("bp_b_cnt", 32'(bus.b_cnt), 32'd2);
      @(posedge clk);
      #1;

      // Mid-stream reset discards buffered words.
      bus.a_ready = 1'b0;
      send(1'b0, 8'hC0);
      send(1'b0, 8'hC1);
      do_reset(1, 1'b0);
      @(negedge clk);
      check("midrst_a_valid", 32'(bus.a_valid), 32'h0);
      @(posedge clk);
      #1;
      bus.a_ready = 1'b1;
      idle(3);

      // Full throughput: 16 back-to-back words to A.
      for (int i = 0; i < 16; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sel   = 1'b0;
         bus.in_data  = 8'(8'h40 + i);
         @(posedge clk);
         #1;
      end
      idle(3);
      @(negedge clk);
      check("thru_a_cnt", 32'(bus.a_cnt), 32'd16);
      @(posedge clk);
      #1;

      // Counter wrap: 17 words to B on the 4-bit-counter instance.
      for (int i = 0; i < 17; i++) send(1'b1, 8'(8'h80 + i));
      idle(3);
      @(negedge clk);
      check("wrap_b_cnt_w4", 32'(bus4.b_cnt), 32'd1);
      check("wrap_b_cnt_w8", 32'(bus.b_cnt), 32'd17);
      @(posedge clk);
      #1;

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         rst_n        = ($urandom_range(0, 99) != 0);
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.in_sel   = 1'($urandom);
         bus.in_data  = 8'($urandom);
         bus.a_ready  = ($urandom_range(0, 3) != 0);
         bus.b_ready  = ($urandom_range(0, 2) == 0);
         @(posedge clk);
         #1;
      end
      rst_n       = 1'b1;
      bus.a_ready = 1'b1;
      bus.b_ready = 1'b1;
      idle(6);
      @(negedge clk);
      check("drain_a_valid", 32'(bus.a_valid), 32'h0);
      check("drain_b_valid", 32'(bus.b_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
